uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  // Arbiter sequencing states, one byte per pass through the loop.
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    GAP
  } arb_state_t;

  // Default byte width for requesters and the transmitter.
  localparam int DATA_W_DEF = 8;

  // Width of an index able to address n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after 'last',
// scanning last+1, last+2, ... modulo N. Usable for any shared resource.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] index
);

  // cand[gi] is the requester examined at scan position gi.
  logic [IW-1:0] cand [N];
  logic [N-1:0]  hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = IW'((32'(last) + 32'(gi) + 32'd1) % 32'(N));
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Lowest scan position with a request wins; iterate high to low so it lands last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        valid = 1'b1;
        index = cand[i];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers. One byte per
// grant, round-robin, sequenced against the transmitter busy flag with an
// inter-byte gap and a timeout in case busy never rises.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 15,
  parameter int CNT_W        = 8,
  localparam int IW          = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_wrsig,
  input  logic                      tx_busy,
  output logic [IW-1:0]             grant_id,
  output logic                      arb_busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IW-1:0]    LAST_RST     = IW'(NUM_REQ - 1);
  // With no gap configured the frame end returns straight to arbitration.
  localparam arb_state_t       AFTER_FRAME  = (GAP_CYCLES == 0) ? IDLE : GAP;

  arb_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IW-1:0]     last_reg;
  logic [IW-1:0]     grant_reg;
  logic [DATA_W-1:0] data_reg;
  logic              load;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;

  // Requester bytes unpacked so the winner can be selected by index.
  logic [DATA_W-1:0] req_bytes [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .last  (last_reg),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // State and gap/timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture winner and its byte in the arbitration cycle; held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg  <= LAST_RST;
      grant_reg <= '0;
      data_reg  <= '0;
    end else if (load) begin
      last_reg  <= pick_idx;
      grant_reg <= pick_idx;
      data_reg  <= req_bytes[pick_idx];
    end
  end

  // Next state, counter update and the ISSUE-only strobe/ack pulses.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    tx_wrsig   = 1'b0;
    ack        = '0;
    arb_busy   = (state_reg != IDLE);
    unique case (state_reg)
      IDLE: begin
        // A transmitter still busy with a foreign frame blocks arbitration.
        if (pick_valid && !tx_busy) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        tx_wrsig        = 1'b1;
        ack[grant_reg]  = 1'b1;
        cnt_next        = '0;
        state_next      = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          // Busy never showed up: treat the byte as sent.
          cnt_next   = '0;
          state_next = AFTER_FRAME;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_next   = '0;
          state_next = AFTER_FRAME;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tx_data  = data_reg;
  assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model plus a per-cycle compare,
// directed scenarios with literal expectations, and a fairness soak.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 8;
  localparam int GAP_CYCLES   = 2;
  localparam int BUSY_TIMEOUT = 15;
  localparam int CNT_W        = 8;
  localparam int IW           = 2;
  localparam int FRAME        = 10;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_wrsig;
  logic                      tx_busy;
  logic [IW-1:0]             grant_id;
  logic                      arb_busy;

  logic model_busy  = 1'b0;
  logic manual_busy = 1'b0;
  logic tx_en       = 1'b1;
  logic soak_on     = 1'b0;
  assign tx_busy = model_busy | manual_busy;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .GAP_CYCLES   (GAP_CYCLES),
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_wrsig (tx_wrsig),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .arb_busy (arb_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter: busy rises one clock after the strobe and stays high FRAME clocks.
  initial begin : tx_model
    forever begin
      @(negedge clk);
      if (tx_en && rst_n && tx_wrsig) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic              exp_wrsig;
  logic [NUM_REQ-1:0] exp_ack;
  logic [DATA_W-1:0] exp_data;
  logic [IW-1:0]     exp_grant;
  logic              exp_busy;
  int                m_ptr;

  task automatic m_clear();
    m_ptr     = NUM_REQ - 1;
    exp_wrsig = 1'b0;
    exp_ack   = '0;
    exp_data  = '0;
    exp_grant = '0;
    exp_busy  = 1'b0;
  endtask

  task automatic tick(output bit ab);
    @(posedge clk);
    ab = !rst_n;
    if (ab) m_clear();
  endtask

  // One byte per loop pass: arbitrate, strobe, wait for the frame, gap.
  initial begin : model
    bit ab;
    bit started;
    int w;
    m_clear();
    forever begin
      tick(ab);
      if (ab) continue;
      if (req == '0 || tx_busy) continue;
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_ptr + k) % NUM_REQ;
        if (w < 0 && req[c]) w = c;
      end
      m_ptr     = w;
      exp_grant = IW'(w);
      exp_data  = req_data[w*DATA_W +: DATA_W];
      exp_wrsig = 1'b1;
      exp_ack   = '0;
      exp_ack[w] = 1'b1;
      exp_busy  = 1'b1;
      tick(ab);
      if (ab) continue;
      exp_wrsig = 1'b0;
      exp_ack   = '0;
      started = 1'b0;
      for (int k = 0; k < BUSY_TIMEOUT; k++) begin
        tick(ab);
        if (ab) break;
        if (tx_busy) begin
          started = 1'b1;
          break;
        end
      end
      if (ab) continue;
      if (started) begin
        do tick(ab); while (!ab && tx_busy);
        if (ab) continue;
      end
      for (int k = 0; k < GAP_CYCLES; k++) begin
        tick(ab);
        if (ab) break;
      end
      if (ab) continue;
      exp_busy = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  int              log_cyc[$];
  int              log_grant[$];
  int              log_data[$];
  int              log_ack[$];
  int              wait_cnt [NUM_REQ];

  initial begin : compare
    logic [DATA_W-1:0] prev_data;
    bit                prev_ok;
    prev_data = '0;
    prev_ok   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_wrsig", tx_wrsig, 0);
        check("rst_ack", ack, 0);
        check("rst_data", tx_data, 0);
        check("rst_grant", grant_id, 0);
        check("rst_arb_busy", arb_busy, 0);
        prev_ok = 1'b0;
      end else begin
        check("wrsig", tx_wrsig, exp_wrsig);
        check("ack", ack, exp_ack);
        check("tx_data", tx_data, exp_data);
        check("grant_id", grant_id, exp_grant);
        check("arb_busy", arb_busy, exp_busy);
        if (prev_ok && tx_busy) check("data_stable_busy", tx_data, prev_data);
        prev_ok   = 1'b1;
        prev_data = tx_data;
        for (int i = 0; i < NUM_REQ; i++) if (!req[i] || !soak_on) wait_cnt[i] = 0;
        if (tx_wrsig) begin
          log_cyc.push_back(cyc);
          log_grant.push_back(int'(grant_id));
          log_data.push_back(int'(tx_data));
          log_ack.push_back(int'(ack));
          $display("byte: cycle %0d grant %0d data %02h ack %b", cyc, grant_id, tx_data, ack);
          if (soak_on) begin
            for (int i = 0; i < NUM_REQ; i++) begin
              if (i == int'(grant_id)) begin
                check("fair_wait", wait_cnt[i] <= NUM_REQ, 1);
                wait_cnt[i] = 0;
              end else if (req[i]) begin
                wait_cnt[i]++;
              end
            end
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_log(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (log_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_arrived"}, log_cyc.size() >= n, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_cyc.delete();
    log_grant.delete();
    log_data.delete();
    log_ack.delete();
  endtask

  initial begin : main
    int p, f, a0;
    logic [NUM_REQ-1:0] a;

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", grant_id, 0);
    check("post_rst_arb_busy", arb_busy, 0);
    check("post_rst_wrsig", tx_wrsig, 0);
    @(posedge clk);
    #1;

    // T1: single requester 0, byte 55, held for two bytes
    p = cyc;
    req = 4'b0001;
    req_data[7:0] = 8'h55;
    wait_log(2, 40, "t1");
    req = '0;
    check("t1_latency", log_cyc[0] - p, 1);
    check("t1_grant", log_grant[0], 0);
    check("t1_data", log_data[0], 8'h55);
    check("t1_ack", log_ack[0], 4'b0001);
    check("t1_spacing", log_cyc[1] - log_cyc[0], 15);
    repeat (20) @(posedge clk);

    // T2: all requesters, round-robin order from a fresh pointer
    do_reset();
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b1111;
    wait_log(5, 100, "t2");
    req = '0;
    check("t2_g0", log_grant[0], 0);
    check("t2_g1", log_grant[1], 1);
    check("t2_g2", log_grant[2], 2);
    check("t2_g3", log_grant[3], 3);
    check("t2_g4", log_grant[4], 0);
    check("t2_d2", log_data[2], 8'hA2);
    check("t2_d4", log_data[4], 8'hA0);
    check("t2_ack3", log_ack[3], 4'b1000);
    check("t2_spacing", log_cyc[4] - log_cyc[3], 15);
    repeat (20) @(posedge clk);

    // T3: transmitter disconnected, busy-start timeout path
    tx_en = 1'b0;
    do_reset();
    req_data[15:8] = 8'h3C;
    req = 4'b0010;
    wait_log(1, 10, "t3a");
    a0 = log_cyc[0];
    while (cyc < a0 + 16) @(negedge clk);
    check("t3_arb_busy_gap", arb_busy, 1);
    check("t3_no_wrsig", tx_wrsig, 0);
    wait_log(2, 40, "t3b");
    req = '0;
    check("t3_grant", log_grant[0], 1);
    check("t3_data", log_data[0], 8'h3C);
    check("t3_spacing", log_cyc[1] - log_cyc[0], 19);
    repeat (25) @(posedge clk);
    tx_en = 1'b1;

    // T4: transmitter busy at reset release holds off arbitration
    @(posedge clk);
    #1 rst_n = 1'b0;
    manual_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_cyc.delete(); log_grant.delete(); log_data.delete(); log_ack.delete();
    req_data[23:16] = 8'hC4;
    req = 4'b0100;
    repeat (20) @(posedge clk);
    #1 manual_busy = 1'b0;
    f = cyc;
    check("t4_held_off", log_cyc.size(), 0);
    wait_log(1, 10, "t4");
    req = '0;
    check("t4_latency", log_cyc[0] - f, 1);
    check("t4_grant", log_grant[0], 2);
    check("t4_data", log_data[0], 8'hC4);
    repeat (20) @(posedge clk);

    // T5: reset mid-frame, then pointer restarts at requester 0
    do_reset();
    req_data[15:8] = 8'h77;
    req = 4'b0010;
    wait_log(1, 10, "t5a");
    repeat (4) @(posedge clk);
    #1;
    check("t5_pre_grant", grant_id, 1);
    check("t5_pre_data", tx_data, 8'h77);
    rst_n = 1'b0;
    req = '0;
    #1;
    check("t5_async_wrsig", tx_wrsig, 0);
    check("t5_async_ack", ack, 0);
    check("t5_async_data", tx_data, 0);
    check("t5_async_grant", grant_id, 0);
    check("t5_async_arb_busy", arb_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_cyc.delete(); log_grant.delete(); log_data.delete(); log_ack.delete();
    req_data[7:0]   = 8'h11;
    req_data[31:24] = 8'h99;
    req = 4'b1001;
    wait_log(2, 60, "t5b");
    req = '0;
    check("t5_first_grant", log_grant[0], 0);
    check("t5_first_data", log_data[0], 8'h11);
    check("t5_second_grant", log_grant[1], 3);
    check("t5_second_data", log_data[1], 8'h99);
    repeat (20) @(posedge clk);

    // T6: random request soak with fairness bound
    do_reset();
    soak_on = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      a = ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && a[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          req[i] = 1'b1;
          req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
      end
    end
    req = '0;
    repeat (40) @(posedge clk);
    soak_on = 1'b0;
    check("soak_grants", log_cyc.size() >= 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
